// File: rtl/branch_predictor_btb.sv
// Branch-target buffer with 2-bit saturating direction counters, registered
// lookup and mispredict/redirect reporting. Optional macro: BTB_PERF_COUNTERS_EN.
module branch_predictor_btb #(
  parameter int NB_ADDR     = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_fetch_valid,
  input  logic [NB_ADDR-1:0] i_fetch_pc,
  output logic               o_pred_valid,
  output logic               o_pred_taken,
  output logic [NB_ADDR-1:0] o_pred_target,
  input  logic               i_res_valid,
  input  logic [NB_ADDR-1:0] i_res_pc,
  input  logic               i_res_is_jump,
  input  logic               i_res_taken,
  input  logic [NB_ADDR-1:0] i_res_target,
  input  logic               i_res_pred_taken,
  input  logic [NB_ADDR-1:0] i_res_pred_target,
  output logic               o_mispredict,
  output logic [NB_ADDR-1:0] o_redirect_pc
`ifdef BTB_PERF_COUNTERS_EN
  ,
  output logic [31:0]        o_perf_resolved,
  output logic [31:0]        o_perf_mispredict
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = NB_ADDR - IDX_W - 2;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [NB_ADDR-1:0] target;
    logic [1:0]         ctr;
    logic               is_jump;
  } entry_t;

  entry_t btb_q [BTB_ENTRIES];

  // Lookup path
  logic [IDX_W-1:0]   f_idx;
  entry_t             f_entry;
  logic               f_hit;
  logic               f_taken;
  logic [NB_ADDR-1:0] f_target;

  always_comb begin
    f_idx    = i_fetch_pc[IDX_W+1:2];
    f_entry  = btb_q[f_idx];
    f_hit    = f_entry.valid && (f_entry.tag == i_fetch_pc[NB_ADDR-1:IDX_W+2]);
    f_taken  = f_hit && (f_entry.is_jump || f_entry.ctr[1]);
    f_target = f_taken ? f_entry.target : i_fetch_pc + NB_ADDR'(4);
  end

  // Resolve path: training write and mispredict detection
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_tag;
  entry_t             r_entry;
  entry_t             r_next;
  logic               r_hit;
  logic               r_write;
  logic [NB_ADDR-1:0] r_clean_target;
  logic [NB_ADDR-1:0] r_actual;
  logic [NB_ADDR-1:0] r_predicted;
  logic               r_mismatch;

  always_comb begin
    r_idx          = i_res_pc[IDX_W+1:2];
    r_tag          = i_res_pc[NB_ADDR-1:IDX_W+2];
    r_entry        = btb_q[r_idx];
    r_hit          = r_entry.valid && (r_entry.tag == r_tag);
    r_clean_target = i_res_target & ~NB_ADDR'(1);
    r_actual       = i_res_taken ? r_clean_target : i_res_pc + NB_ADDR'(4);
    r_predicted    = i_res_pred_taken ? i_res_pred_target : i_res_pc + NB_ADDR'(4);
    r_mismatch     = (r_actual != r_predicted);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    r_next  = r_entry;
    r_write = 1'b0;
    if (i_res_valid) begin
      if (r_hit) begin
        r_write = 1'b1;
        if (!i_res_is_jump) begin
          if (i_res_taken) r_next.ctr = (r_entry.ctr == 2'b11) ? 2'b11 : r_entry.ctr + 2'd1;
          else             r_next.ctr = (r_entry.ctr == 2'b00) ? 2'b00 : r_entry.ctr - 2'd1;
        end
        if (i_res_taken) r_next.target = r_clean_target;
      end else if (i_res_taken) begin
        r_write        = 1'b1;
        r_next.valid   = 1'b1;
        r_next.tag     = r_tag;
        r_next.target  = r_clean_target;
        r_next.ctr     = 2'b10;
        r_next.is_jump = i_res_is_jump;
      end
    end
  end

  // NOTE: the table is reset explicitly because counters must start at weakly
  // not-taken; it therefore maps to flops, not a RAM macro.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01, is_jump: 1'b0};
      end
    end else if (r_write) begin
      btb_q[r_idx] <= r_next;
    end
  end

  // Prediction register: taken/target hold when no lookup is accepted
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_pred_valid  <= 1'b0;
      o_pred_taken  <= 1'b0;
      o_pred_target <= '0;
    end else if (i_fetch_valid && !i_flush) begin
      o_pred_valid  <= 1'b1;
      o_pred_taken  <= f_taken;
      o_pred_target <= f_target;
    end else begin
      o_pred_valid  <= 1'b0;
    end
  end

  // Flush does not suppress the recovery report for an older instruction
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_mispredict  <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      o_mispredict <= i_res_valid && r_mismatch;
      if (i_res_valid) o_redirect_pc <= r_actual;
    end
  end

`ifdef BTB_PERF_COUNTERS_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_perf_resolved   <= '0;
      o_perf_mispredict <= '0;
    end else if (i_res_valid) begin
      o_perf_resolved <= o_perf_resolved + 32'd1;
      if (r_mismatch) o_perf_mispredict <= o_perf_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb; covers BTB_PERF_COUNTERS_EN when defined.
module tb_branch_predictor_btb;

  logic        i_clock;
  logic        i_reset;
  logic        i_flush;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_pc;
  logic        o_pred_valid;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_res_valid;
  logic [31:0] i_res_pc;
  logic        i_res_is_jump;
  logic        i_res_taken;
  logic [31:0] i_res_target;
  logic        i_res_pred_taken;
  logic [31:0] i_res_pred_target;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
`ifdef BTB_PERF_COUNTERS_EN
  logic [31:0] o_perf_resolved;
  logic [31:0] o_perf_mispredict;
`endif

  branch_predictor_btb #(.NB_ADDR(32), .BTB_ENTRIES(16)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_flush          (i_flush),
    .i_fetch_valid    (i_fetch_valid),
    .i_fetch_pc       (i_fetch_pc),
    .o_pred_valid     (o_pred_valid),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .i_res_valid      (i_res_valid),
    .i_res_pc         (i_res_pc),
    .i_res_is_jump    (i_res_is_jump),
    .i_res_taken      (i_res_taken),
    .i_res_target     (i_res_target),
    .i_res_pred_taken (i_res_pred_taken),
    .i_res_pred_target(i_res_pred_target),
    .o_mispredict     (o_mispredict),
    .o_redirect_pc    (o_redirect_pc)
`ifdef BTB_PERF_COUNTERS_EN
    ,
    .o_perf_resolved  (o_perf_resolved),
    .o_perf_mispredict(o_perf_mispredict)
`endif
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef struct {
    logic        check_redirect;
    logic        mis;
    logic [31:0] redirect;
  } mis_t;

  typedef struct {
    bit        valid;
    bit [25:0] tag;
    bit [31:0] target;
    bit [1:0]  ctr;
    bit        is_jump;
  } m_entry_t;

  pred_t    pred_q[$];
  mis_t     mis_q[$];
  m_entry_t model [16];
  logic        held_taken;
  logic [31:0] held_target;
  int unsigned exp_resolved;
  int unsigned exp_mispredict;
  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = '{valid: 0, tag: '0, target: '0, ctr: 2'b01, is_jump: 0};
    held_taken     = 1'b0;
    held_target    = '0;
    exp_resolved   = 0;
    exp_mispredict = 0;
  endtask

  task automatic cycle(input logic fv, input logic [31:0] fpc, input logic fl,
                       input logic rv, input logic [31:0] rpc, input logic isj,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    pred_t p;
    mis_t m;
    int fi, ri;
    logic hit;
    logic [31:0] act, prd;
    i_fetch_valid = fv;  i_fetch_pc = fpc; i_flush = fl;
    i_res_valid = rv; i_res_pc = rpc; i_res_is_jump = isj; i_res_taken = tk;
    i_res_target = tgt; i_res_pred_taken = ptk; i_res_pred_target = ptgt;

    // Lookup sees the table before this cycle's update
    fi = int'(fpc[5:2]);
    if (fv && !fl) begin
      hit         = model[fi].valid && (model[fi].tag == fpc[31:6]);
      p.valid     = 1'b1;
      p.taken     = hit && (model[fi].is_jump || model[fi].ctr[1]);
      p.target    = p.taken ? model[fi].target : fpc + 32'd4;
      held_taken  = p.taken;
      held_target = p.target;
    end else begin
      p.valid  = 1'b0;
      p.taken  = held_taken;
      p.target = held_target;
    end
    pred_q.push_back(p);

    act = tk ? (tgt & 32'hFFFF_FFFE) : rpc + 32'd4;
    prd = ptk ? ptgt : rpc + 32'd4;
    m.check_redirect = rv;
    m.mis            = rv && (act != prd);
    m.redirect       = act;
    mis_q.push_back(m);

    if (rv) begin
      exp_resolved++;
      if (act != prd) exp_mispredict++;
      ri  = int'(rpc[5:2]);
      hit = model[ri].valid && (model[ri].tag == rpc[31:6]);
      if (hit) begin
        if (!isj) begin
          if (tk && model[ri].ctr != 2'b11) model[ri].ctr++;
          if (!tk && model[ri].ctr != 2'b00) model[ri].ctr--;
        end
        if (tk) model[ri].target = tgt & 32'hFFFF_FFFE;
      end else if (tk) begin
        model[ri] = '{valid: 1, tag: rpc[31:6], target: tgt & 32'hFFFF_FFFE, ctr: 2'b10, is_jump: isj};
      end
    end

    @(posedge i_clock);
    #1;
    p = pred_q.pop_front();
    check("pred_valid", {31'd0, o_pred_valid}, {31'd0, p.valid});
    check("pred_taken", {31'd0, o_pred_taken}, {31'd0, p.taken});
    check("pred_target", o_pred_target, p.target);
    m = mis_q.pop_front();
    check("mispredict", {31'd0, o_mispredict}, {31'd0, m.mis});
    if (m.check_redirect) check("redirect_pc", o_redirect_pc, m.redirect);
  endtask

  task automatic fetch(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic isj, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    cycle(1'b0, '0, 1'b0, 1'b1, pc, isj, tk, tgt, ptk, ptgt);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    i_reset = 1'b0;
    i_flush = 0; i_fetch_valid = 0; i_fetch_pc = '0;
    i_res_valid = 0; i_res_pc = '0; i_res_is_jump = 0; i_res_taken = 0;
    i_res_target = '0; i_res_pred_taken = 0; i_res_pred_target = '0;
    #2;
    check("rst_pred_valid", {31'd0, o_pred_valid}, 32'd0);
    check("rst_pred_target", o_pred_target, 32'd0);
    check("rst_mispredict", {31'd0, o_mispredict}, 32'd0);
    check("rst_redirect", o_redirect_pc, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;

    // Cold lookup, then train a taken branch
    fetch(32'h100);
    resolve(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    fetch(32'h100);
    // Walk the counter down: 10 -> 01 -> 00 -> 00, then up to 01 (still not-taken)
    resolve(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    fetch(32'h100);
    resolve(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch(32'h100);
    resolve(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    fetch(32'h100);

    // JAL with odd target, aliasing index with different tag
    resolve(32'h200, 1'b1, 1'b1, 32'h401, 1'b0, 32'h0);
    fetch(32'h240);
    fetch(32'h200);

    // Same-cycle lookup and update to the same index: old then new
    cycle(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h88, 1'b0, 32'h0);
    fetch(32'h100);

    // Flush squashes the prediction but not a concurrent mispredict report
    cycle(1'b1, 32'h200, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    cycle(1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    fetch(32'h300);

    // Address wrap at the top of the space
    resolve(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    fetch(32'hFFFF_FFFC);
    resolve(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Replacing the 0x200 entry with an aliasing jump evicts it
    fetch(32'h200);
    resolve(32'h240, 1'b1, 1'b1, 32'h800, 1'b0, 32'h0);
    fetch(32'h200);
    fetch(32'h240);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Reset asserted while an allocating update is pending
    i_res_valid = 1'b1; i_res_pc = 32'h340; i_res_is_jump = 1'b0;
    i_res_taken = 1'b1; i_res_target = 32'h900; i_res_pred_taken = 1'b0;
    i_fetch_valid = 1'b1; i_fetch_pc = 32'h240;
    #3;
    i_reset = 1'b0;
    #1;
    check("mid_rst_pred_valid", {31'd0, o_pred_valid}, 32'd0);
    check("mid_rst_pred_taken", {31'd0, o_pred_taken}, 32'd0);
    check("mid_rst_pred_target", o_pred_target, 32'd0);
    check("mid_rst_mispredict", {31'd0, o_mispredict}, 32'd0);
    check("mid_rst_redirect", o_redirect_pc, 32'd0);
    @(posedge i_clock);
    #1;
    check("held_rst_mispredict", {31'd0, o_mispredict}, 32'd0);
    i_res_valid = 1'b0; i_fetch_valid = 1'b0;
    model_reset();
    @(negedge i_clock);
    i_reset = 1'b1;
    fetch(32'h340);
    fetch(32'h100);
    fetch(32'h240);

    // Three resolves, exactly one mispredict
    resolve(32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve(32'h504, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    resolve(32'h504, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600);
`ifdef BTB_PERF_COUNTERS_EN
    check("perf_resolved", o_perf_resolved, exp_resolved);
    check("perf_mispredict", o_perf_mispredict, exp_mispredict);
`endif
    fetch(32'h504);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
